fifo_odd_even_wr: RTL and testbench

FIFO_ODD_EVEN_WR -- requirements
Module: fifo_odd_even_wr

---
 rtl/fifo_oe_pkg.sv | 12 +
 rtl/fifo_odd_even_wr.sv | 155 +++++++++++++++
 tb/tb_fifo_odd_even_wr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_oe_pkg.sv
// Shared types and constants for the odd/even FIFO write splitter.
package fifo_oe_pkg;

  localparam int DW_DEFAULT = 64;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WR      = 2'd1,
    TAIL    = 2'd2
  } state_e;

endpackage : fifo_oe_pkg

// File: rtl/fifo_odd_even_wr.sv
// Splits a word stream into even/odd FIFOs, up to two entries per FIFO per write.
// Optional macro FIFO_OE_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_odd_even_wr
  import fifo_oe_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  input  logic            fifo_afull,
  output logic [2*DW-1:0] fifo0_wd,
  output logic [2*DW-1:0] fifo1_wd,
  output logic            fifo0_wen,
  output logic            fifo1_wen,
  output logic            fifo_w2entry,
  output logic            frame_done
`ifdef FIFO_OE_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [1:0]    r_cnt;
  logic [2:0]    r_n;
  logic          r_last;
  logic          r_run;
  logic [DW-1:0] r_buf [4];

  logic            w_accept;
  logic            w_wen0;
  logic            w_wen1;
  logic            w_w2;
  logic            w_done;
  logic [2*DW-1:0] w_wd0;
  logic [2*DW-1:0] w_wd1;

  // r_run keeps in_rdy low until the first clock after reset release.
  assign in_rdy   = r_run & (r_state == COLLECT);
  assign w_accept = in_vld & in_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_wen0      = 1'b0;
    w_wen1      = 1'b0;
    w_w2        = 1'b0;
    w_done      = 1'b0;
    w_wd0       = '0;
    w_wd1       = '0;
    case (r_state)
      COLLECT: begin
        if (w_accept && ((r_cnt == 2'd3) || in_last)) begin
          w_state_nxt = WR;
        end
      end
      WR: begin
        if (!fifo_afull) begin
          w_wen0            = 1'b1;
          w_wd0[DW-1:0]     = r_buf[0];
          case (r_n)
            3'd1: begin
              w_done      = r_last;
              w_state_nxt = COLLECT;
            end
            3'd2: begin
              w_wen1        = 1'b1;
              w_wd1[DW-1:0] = r_buf[1];
              w_done        = r_last;
              w_state_nxt   = COLLECT;
            end
            3'd3: begin
              // Third word goes to fifo0 alone on the following cycle.
              w_wen1        = 1'b1;
              w_wd1[DW-1:0] = r_buf[1];
              w_state_nxt   = TAIL;
            end
            default: begin
              w_wen1        = 1'b1;
              w_w2          = 1'b1;
              w_wd0         = {r_buf[2], r_buf[0]};
              w_wd1         = {r_buf[3], r_buf[1]};
              w_done        = r_last;
              w_state_nxt   = COLLECT;
            end
          endcase
        end
      end
      TAIL: begin
        if (!fifo_afull) begin
          w_wen0        = 1'b1;
          w_wd0[DW-1:0] = r_buf[2];
          w_done        = r_last;
          w_state_nxt   = COLLECT;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  assign fifo0_wen    = w_wen0;
  assign fifo1_wen    = w_wen1;
  assign fifo_w2entry = w_w2;
  assign fifo0_wd     = w_wd0;
  assign fifo1_wd     = w_wd1;
  assign frame_done   = w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_cnt   <= 2'd0;
      r_n     <= 3'd0;
      r_last  <= 1'b0;
      r_run   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_buf[r_cnt] <= in_data;
        r_cnt        <= r_cnt + 2'd1;
        if ((r_cnt == 2'd3) || in_last) begin
          r_n    <= {1'b0, r_cnt} + 3'd1;
          r_last <= in_last;
        end
      end
      if ((r_state != COLLECT) && (w_state_nxt == COLLECT)) begin
        r_cnt <= 2'd0;
      end
    end
  end

`ifdef FIFO_OE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state != COLLECT) && fifo_afull && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule : fifo_odd_even_wr

// File: tb/tb_fifo_odd_even_wr.sv
// Directed bench for fifo_odd_even_wr: vector table plus stall and reset sequences.
module tb_fifo_odd_even_wr;

  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic            in_vld;
  logic            in_rdy;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            fifo_afull;
  logic [2*DW-1:0] fifo0_wd;
  logic [2*DW-1:0] fifo1_wd;
  logic            fifo0_wen;
  logic            fifo1_wen;
  logic            fifo_w2entry;
  logic            frame_done;
`ifdef FIFO_OE_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  fifo_odd_even_wr #(.DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_data      (in_data),
    .in_last      (in_last),
    .fifo_afull   (fifo_afull),
    .fifo0_wd     (fifo0_wd),
    .fifo1_wd     (fifo1_wd),
    .fifo0_wen    (fifo0_wen),
    .fifo1_wen    (fifo1_wen),
    .fifo_w2entry (fifo_w2entry),
    .frame_done   (frame_done)
`ifdef FIFO_OE_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            vld;
    logic [DW-1:0]   data;
    logic            last;
    logic            afull;
    logic            rdy;
    logic            wen0;
    logic            wen1;
    logic            w2;
    logic [2*DW-1:0] wd0;
    logic [2*DW-1:0] wd1;
    logic            done;
  } vec_t;

  int n_chk;
  int n_fail;

  function automatic vec_t mk(logic vld, logic [DW-1:0] data, logic last, logic afull,
                              logic rdy, logic wen0, logic wen1, logic w2,
                              logic [2*DW-1:0] wd0, logic [2*DW-1:0] wd1, logic done);
    vec_t v;
    v.vld = vld; v.data = data; v.last = last; v.afull = afull;
    v.rdy = rdy; v.wen0 = wen0; v.wen1 = wen1; v.w2 = w2;
    v.wd0 = wd0; v.wd1 = wd1; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic vld, input logic [DW-1:0] data, input logic last, input logic afull);
    @(negedge clk);
    in_vld     = vld;
    in_data    = data;
    in_last    = last;
    fifo_afull = afull;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic wen0, input logic wen1,
                          input logic w2, input logic [2*DW-1:0] wd0, input logic [2*DW-1:0] wd1,
                          input logic done);
    chk({tag, ".rdy"},  {127'd0, in_rdy},       {127'd0, rdy});
    chk({tag, ".wen0"}, {127'd0, fifo0_wen},    {127'd0, wen0});
    chk({tag, ".wen1"}, {127'd0, fifo1_wen},    {127'd0, wen1});
    chk({tag, ".w2"},   {127'd0, fifo_w2entry}, {127'd0, w2});
    chk({tag, ".wd0"},  fifo0_wd,               wd0);
    chk({tag, ".wd1"},  fifo1_wd,               wd1);
    chk({tag, ".done"}, {127'd0, frame_done},   {127'd0, done});
  endtask

  vec_t tbl [21];

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_vld     = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    fifo_afull = 1'b0;

    // 8-word frame, 1-word frame, 3-word frame (inputs ignored while busy), 2-word frame.
    tbl[0]  = mk(1, 64'h1,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[1]  = mk(1, 64'h2,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[2]  = mk(1, 64'h3,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[3]  = mk(1, 64'h4,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[4]  = mk(1, 64'h99, 0, 0, 0, 1, 1, 1, {64'h3, 64'h1}, {64'h4, 64'h2}, 0);
    tbl[5]  = mk(1, 64'h5,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[6]  = mk(1, 64'h6,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[7]  = mk(1, 64'h7,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[8]  = mk(1, 64'h8,  1, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[9]  = mk(0, 64'h0,  0, 0, 0, 1, 1, 1, {64'h7, 64'h5}, {64'h8, 64'h6}, 1);
    tbl[10] = mk(1, 64'hA,  1, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[11] = mk(0, 64'h0,  0, 0, 0, 1, 0, 0, {64'h0, 64'hA}, '0, 1);
    tbl[12] = mk(1, 64'hA,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[13] = mk(1, 64'hB,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[14] = mk(1, 64'hC,  1, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[15] = mk(1, 64'hEE, 0, 0, 0, 1, 1, 0, {64'h0, 64'hA}, {64'h0, 64'hB}, 0);
    tbl[16] = mk(1, 64'hEE, 1, 0, 0, 1, 0, 0, {64'h0, 64'hC}, '0, 1);
    tbl[17] = mk(0, 64'h0,  0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[18] = mk(1, 64'h11, 0, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[19] = mk(1, 64'h22, 1, 0, 1, 0, 0, 0, '0, '0, 0);
    tbl[20] = mk(0, 64'h0,  0, 0, 0, 1, 1, 0, {64'h0, 64'h11}, {64'h0, 64'h22}, 1);

    // Reset state while rst_n is held low.
    drive(0, '0, 0, 0);
    chk_outs("reset", 0, 0, 0, 0, '0, '0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({"post_release.rdy"}, {127'd0, in_rdy}, 128'd0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].last, tbl[i].afull);
      $display("vec %0d: rdy=%0b wen=%0b%0b w2=%0b wd0=%h wd1=%h done=%0b",
               i, in_rdy, fifo0_wen, fifo1_wen, fifo_w2entry, fifo0_wd, fifo1_wd, frame_done);
      chk_outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].wen0, tbl[i].wen1, tbl[i].w2,
               tbl[i].wd0, tbl[i].wd1, tbl[i].done);
    end

    // Stall: full group held off by fifo_afull for 5 cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h21 + 64'(i), 0, 0);
      chk_outs($sformatf("stall_fill%0d", i), 1, 0, 0, 0, '0, '0, 0);
    end
    for (int s = 0; s < 5; s++) begin
      drive(1, 64'hDD, 0, 1);
      chk_outs($sformatf("stall%0d", s), 0, 0, 0, 0, '0, '0, 0);
    end
    drive(0, '0, 0, 0);
    $display("stall release: wen=%0b%0b wd0=%h wd1=%h", fifo0_wen, fifo1_wen, fifo0_wd, fifo1_wd);
    chk_outs("stall_wr", 0, 1, 1, 1, {64'h23, 64'h21}, {64'h24, 64'h22}, 0);
`ifdef FIFO_OE_STALL_CNT_EN
    chk("stall_cnt", {112'd0, stall_cnt}, 128'd5);
`endif

    // Reset while in TAIL of a 3-word frame discards the pending word.
    drive(1, 64'h31, 0, 0);
    drive(1, 64'h32, 0, 0);
    drive(1, 64'h33, 1, 0);
    drive(0, '0, 0, 0);
    chk_outs("rst_wr", 0, 1, 1, 0, {64'h0, 64'h31}, {64'h0, 64'h32}, 0);
    drive(0, '0, 0, 1);
    chk_outs("rst_tail_hold", 0, 0, 0, 0, '0, '0, 0);
    rst_n = 1'b0;
    #1;
    $display("reset in tail: rdy=%0b wen=%0b%0b done=%0b", in_rdy, fifo0_wen, fifo1_wen, frame_done);
    chk_outs("rst_in_tail", 0, 0, 0, 0, '0, '0, 0);
    drive(0, '0, 0, 0);
    chk_outs("rst_held", 0, 0, 0, 0, '0, '0, 0);
`ifdef FIFO_OE_STALL_CNT_EN
    chk("stall_cnt_rst", {112'd0, stall_cnt}, 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release.rdy", {127'd0, in_rdy}, 128'd0);
    drive(1, 64'h41, 0, 0);
    chk_outs("post_rst0", 1, 0, 0, 0, '0, '0, 0);
    drive(1, 64'h42, 1, 0);
    chk_outs("post_rst1", 1, 0, 0, 0, '0, '0, 0);
    drive(0, '0, 0, 0);
    $display("post-reset frame: wen=%0b%0b wd0=%h wd1=%h done=%0b",
             fifo0_wen, fifo1_wen, fifo0_wd, fifo1_wd, frame_done);
    chk_outs("post_rst_wr", 0, 1, 1, 0, {64'h0, 64'h41}, {64'h0, 64'h42}, 1);
    drive(0, '0, 0, 0);
    chk_outs("post_rst_idle", 1, 0, 0, 0, '0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fifo_odd_even_wr
